rob: RTL and testbench
======================

ROB -- requirements
Module: rob

Interface
REQ-001 Parameter DEPTH, default 16: number of entries; power of two.
REQ-002 Parameter TAG_W, default 4: tag width, log2(DEPTH).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 rdy  in  1  global enable; low freezes all state.
REQ-006 alloc_valid  in  1  ID requests an entry this cycle.
REQ-007 alloc_reg_dest  in  5  destination register of the allocating instruction; 0 = none.
REQ-008 alloc_tag  out  TAG_W  combinational tag of the entry the next allocation receives (tail).
REQ-009 full  out  1  combinational; high when count == DEPTH.
REQ-010 cdb_valid  in  1  execution result broadcast.
REQ-011 cdb_tag  in  TAG_W  entry the result belongs to.
REQ-012 cdb_data  in  32  result value.
REQ-013 cdb_mispredict  in  1  result is a mispredicted branch.
REQ-014 cdb_target  in  32  correct PC when cdb_mispredict is high.
REQ-015 ROB_data_valid  out  1  registered one-cycle commit pulse to the register file.
REQ-016 ROB_reg_dest  out  5  committed destination register.
REQ-017 ROB_tag  out  TAG_W  committed entry tag.
REQ-018 ROB_data  out  32  committed value.
REQ-019 clear  out  1  registered one-cycle pipeline flush pulse.
REQ-020 clear_pc  out  32  redirect PC, valid while clear is high.

Function
REQ-021 Circular buffer: head, tail pointers (TAG_W bits, wrap DEPTH-1 -> 0 naturally) and count (TAG_W+1 bits); entry = {busy, ready, mispredict, dest, data, target}.
REQ-022 Allocate when rdy && alloc_valid && !full: entry[tail] <= {busy=1, ready=0, mispredict=0, dest=alloc_reg_dest}; tail++. alloc_valid while full is ignored; no state change.
REQ-023 CDB write when rdy && cdb_valid && entry[cdb_tag].busy: ready=1, data, mispredict, target stored; CDB to non-busy entry ignored.
REQ-024 Commit at most one entry per cycle: when rdy && entry[head].busy && entry[head].ready, next edge drives ROB_data_valid=1, ROB_reg_dest=dest, ROB_tag=head, ROB_data=data; entry busy cleared; head++.
REQ-025 No commit in a cycle: ROB_data_valid=0 at next edge; other commit outputs hold.
REQ-026 Allocate and commit same cycle: count unchanged; full evaluated on pre-edge count, so full ROB rejects allocation even while committing.
REQ-027 Commit latency: CDB result for head entry at edge N sets ready; commit pulse appears after edge N+1.
REQ-028 Committing entry with mispredict=1: commit pulse issued as normal, plus clear=1, clear_pc=target at same edge; all entries' busy cleared, head=tail=0, count=0; allocation and CDB writes in that cycle discarded.
REQ-029 clear deasserts the following edge unless another flush occurs (impossible while ROB empty).
REQ-030 rdy=0: no allocation, CDB write, or commit; ROB_data_valid and clear driven 0 at next edge.

Reset
REQ-031 rst high asynchronously: head=tail=count=0, all busy=0, ROB_data_valid=0, ROB_reg_dest=0, ROB_tag=0, ROB_data=0, clear=0, clear_pc=0; full=0, alloc_tag=0.
REQ-032 rst asserted mid-operation discards all in-flight entries; no commit pulse follows deassertion until a new entry completes.

Configuration
REQ-033 Macro ROB_COMMIT_BYPASS_EN defined: when the head entry is busy and not ready and cdb_valid targets head, commit occurs at that same edge using cdb_data/cdb_mispredict/cdb_target (latency 1 edge). Undefined: REQ-027 latency (2 edges) applies; no bypass path exists.

Verification
REQ-034 Reset, allocate dest 5 (tag 0), CDB tag 0 data 0x1234 -> two edges later ROB_data_valid=1, ROB_reg_dest=5, ROB_tag=0, ROB_data=0x1234 for one cycle.
REQ-035 Allocate 16 entries without CDB -> full=1, 17th alloc_valid ignored, alloc_tag=0; complete tag 0 -> commit, full drops, next allocation gets tag 0 (wrap).
REQ-036 Allocate tags 0,1,2; CDB tag 2 then tag 1 then tag 0 -> commits strictly in order 0,1,2 on consecutive cycles.
REQ-037 Allocate tags 0,1; CDB tag 0 mispredict target 0x80 -> commit of tag 0 with clear=1, clear_pc=0x80; later CDB tag 1 produces no commit; alloc_tag=0.
REQ-038 Hold rdy=0 with ready head entry for 3 cycles -> no commit; rdy=1 -> commit next edge.
REQ-039 With ROB_COMMIT_BYPASS_EN, CDB on head tag -> commit pulse after that single edge.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions that retires
// results in program order, one per cycle, and flushes on a mispredicted
// branch reaching the head.
// Optional feature: define ROB_COMMIT_BYPASS_EN to let a CDB result aimed at
// the head entry commit on the same edge it arrives (one-edge latency).
module rob #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_reg_dest,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    input  logic             cdb_mispredict,
    input  logic [31:0]      cdb_target,
    output logic             ROB_data_valid,
    output logic [4:0]       ROB_reg_dest,
    output logic [TAG_W-1:0] ROB_tag,
    output logic [31:0]      ROB_data,
    output logic             clear,
    output logic [31:0]      clear_pc
);

    logic             busy_q   [DEPTH];
    logic             ready_q  [DEPTH];
    logic             misp_q   [DEPTH];
    logic [4:0]       dest_q   [DEPTH];
    logic [31:0]      data_q   [DEPTH];
    logic [31:0]      target_q [DEPTH];

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic             do_alloc;
    logic             do_cdb;
    logic             bypass_hit;
    logic             commit_normal;
    logic             do_commit;
    logic             do_flush;
    logic [31:0]      commit_data;
    logic             commit_misp;
    logic [31:0]      commit_target;

    assign full      = (count_q == (TAG_W+1)'(DEPTH));
    assign alloc_tag = tail_q;

    // Full is judged on the pre-edge count, so a full ROB refuses allocation
    // even in a cycle where it also retires an entry.
    assign do_alloc      = rdy && alloc_valid && !full;
    assign do_cdb        = rdy && cdb_valid && busy_q[cdb_tag];
    assign commit_normal = rdy && busy_q[head_q] && ready_q[head_q];

`ifdef ROB_COMMIT_BYPASS_EN
    assign bypass_hit = rdy && busy_q[head_q] && !ready_q[head_q]
                        && cdb_valid && (cdb_tag == head_q);
`else
    assign bypass_hit = 1'b0;
`endif

    assign do_commit     = commit_normal || bypass_hit;
    assign commit_data   = bypass_hit ? cdb_data       : data_q[head_q];
    assign commit_misp   = bypass_hit ? cdb_mispredict : misp_q[head_q];
    assign commit_target = bypass_hit ? cdb_target     : target_q[head_q];
    assign do_flush      = do_commit && commit_misp;

    // Next pointer and occupancy; a flush empties the buffer and rewinds to 0.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_alloc)
                tail_d = tail_q + TAG_W'(1);
            if (do_commit)
                head_d = head_q + TAG_W'(1);
            case ({do_alloc, do_commit})
                2'b10:   count_d = count_q + (TAG_W+1)'(1);
                2'b01:   count_d = count_q - (TAG_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: allocate at tail, fill from CDB, release at head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]   <= 1'b0;
                ready_q[i]  <= 1'b0;
                misp_q[i]   <= 1'b0;
                dest_q[i]   <= '0;
                data_q[i]   <= '0;
                target_q[i] <= '0;
            end
        end else if (do_flush) begin
            for (int i = 0; i < DEPTH; i++)
                busy_q[i] <= 1'b0;
        end else begin
            if (do_alloc) begin
                busy_q[tail_q]  <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                misp_q[tail_q]  <= 1'b0;
                dest_q[tail_q]  <= alloc_reg_dest;
            end
            if (do_cdb) begin
                ready_q[cdb_tag]  <= 1'b1;
                data_q[cdb_tag]   <= cdb_data;
                misp_q[cdb_tag]   <= cdb_mispredict;
                target_q[cdb_tag] <= cdb_target;
            end
            if (do_commit)
                busy_q[head_q] <= 1'b0;
        end
    end

    // Registered commit and flush pulses; payload fields hold between commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ROB_data_valid <= 1'b0;
            ROB_reg_dest   <= '0;
            ROB_tag        <= '0;
            ROB_data       <= '0;
            clear          <= 1'b0;
            clear_pc       <= '0;
        end else begin
            ROB_data_valid <= do_commit;
            clear          <= do_flush;
            if (do_commit) begin
                ROB_reg_dest <= dest_q[head_q];
                ROB_tag      <= head_q;
                ROB_data     <= commit_data;
            end
            if (do_flush)
                clear_pc <= commit_target;
        end
    end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_rob;
    localparam int DEPTH = 16;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rdy = 1'b0;
    logic             alloc_valid = 1'b0;
    logic [4:0]       alloc_reg_dest = '0;
    logic [TAG_W-1:0] alloc_tag;
    logic             full;
    logic             cdb_valid = 1'b0;
    logic [TAG_W-1:0] cdb_tag = '0;
    logic [31:0]      cdb_data = '0;
    logic             cdb_mispredict = 1'b0;
    logic [31:0]      cdb_target = '0;
    logic             ROB_data_valid;
    logic [4:0]       ROB_reg_dest;
    logic [TAG_W-1:0] ROB_tag;
    logic [31:0]      ROB_data;
    logic             clear;
    logic [31:0]      clear_pc;

    rob #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_reg_dest(alloc_reg_dest),
        .alloc_tag(alloc_tag), .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .ROB_data_valid(ROB_data_valid), .ROB_reg_dest(ROB_reg_dest),
        .ROB_tag(ROB_tag), .ROB_data(ROB_data),
        .clear(clear), .clear_pc(clear_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  dest;
        bit          done;
        bit          misp;
        logic [31:0] data;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    int          mHead;
    bit          expValid;
    logic [4:0]  expDest;
    logic [TAG_W-1:0] expTag;
    logic [31:0] expData;
    bit          expClear;
    logic [31:0] expClearPc;

    int checks = 0;
    int failures = 0;
    int seen[4];
    int seenTag[4];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mHead = 0;
        expValid = 0; expDest = '0; expTag = '0; expData = '0;
        expClear = 0; expClearPc = '0;
    endtask

    // Program-order model: queue front is the oldest in-flight instruction.
    task automatic modelStep(input bit r, input bit av, input logic [4:0] d,
                             input bit cv, input logic [TAG_W-1:0] ct,
                             input logic [31:0] cd, input bit cm, input logic [31:0] ctg);
        bit   com = 0;
        bit   fl = 0;
        ent_t c;
        ent_t e;
        int   idx;
        int   sz = mq.size();
        expValid = 0;
        expClear = 0;
        if (!r) return;
        if (sz > 0 && mq[0].done) begin
            com = 1; c = mq[0];
        end
`ifdef ROB_COMMIT_BYPASS_EN
        else if (sz > 0 && cv && int'(ct) == mHead) begin
            com = 1; c = mq[0]; c.data = cd; c.misp = cm; c.tgt = ctg;
        end
`endif
        if (com) begin
            expValid = 1;
            expDest  = c.dest;
            expTag   = TAG_W'(mHead);
            expData  = c.data;
            if (c.misp) begin
                fl = 1; expClear = 1; expClearPc = c.tgt;
            end
        end
        if (fl) begin
            mq.delete();
            mHead = 0;
        end else begin
            if (cv) begin
                idx = (int'(ct) - mHead + DEPTH) % DEPTH;
                if (idx < sz) begin
                    e = mq[idx]; e.done = 1; e.data = cd; e.misp = cm; e.tgt = ctg;
                    mq[idx] = e;
                end
            end
            if (av && sz < DEPTH) begin
                e.dest = d; e.done = 0; e.misp = 0; e.data = '0; e.tgt = '0;
                mq.push_back(e);
            end
            if (com) begin
                void'(mq.pop_front());
                mHead = (mHead + 1) % DEPTH;
            end
        end
    endtask

    task automatic checkOutput();
        cmp("ROB_data_valid", 32'(ROB_data_valid), 32'(expValid));
        cmp("ROB_reg_dest", 32'(ROB_reg_dest), 32'(expDest));
        cmp("ROB_tag", 32'(ROB_tag), 32'(expTag));
        cmp("ROB_data", ROB_data, expData);
        cmp("clear", 32'(clear), 32'(expClear));
        cmp("clear_pc", clear_pc, expClearPc);
        cmp("full", 32'(full), 32'(mq.size() == DEPTH));
        cmp("alloc_tag", 32'(alloc_tag), 32'((mHead + mq.size()) % DEPTH));
    endtask

    // Called at a falling edge: drive one cycle, advance model, check after the edge.
    task automatic applyStimulus(input bit r, input bit av, input logic [4:0] d,
                                 input bit cv, input logic [TAG_W-1:0] ct,
                                 input logic [31:0] cd, input bit cm, input logic [31:0] ctg);
        rdy = r; alloc_valid = av; alloc_reg_dest = d;
        cdb_valid = cv; cdb_tag = ct; cdb_data = cd; cdb_mispredict = cm; cdb_target = ctg;
        modelStep(r, av, d, cv, ct, cd, cm, ctg);
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1, 0, 5'd0, 0, '0, 32'd0, 0, 32'd0);
    endtask

    task automatic alloc(input logic [4:0] d);
        applyStimulus(1, 1, d, 0, '0, 32'd0, 0, 32'd0);
    endtask

    task automatic cdb(input logic [TAG_W-1:0] t, input logic [31:0] v, input bit m, input logic [31:0] tg);
        applyStimulus(1, 0, 5'd0, 1, t, v, m, tg);
    endtask

    // Asynchronous reset pulse raised between clock edges; outputs must clear at once.
    task automatic doReset();
        @(negedge clk);
        rdy = 0; alloc_valid = 0; cdb_valid = 0;
        #2 rst = 1;
        #1;
        modelReset();
        cmp("rst_valid", 32'(ROB_data_valid), 32'd0);
        cmp("rst_clear", 32'(clear), 32'd0);
        cmp("rst_full", 32'(full), 32'd0);
        cmp("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        modelReset();
        repeat (2) @(negedge clk);
        cmp("init_rob_data", ROB_data, 32'd0);
        cmp("init_clear_pc", clear_pc, 32'd0);
        rst = 0;
        doReset();

        // Basic allocate / complete / commit.
        alloc(5'd5);
        cmp("lit034_alloc_tag", 32'(alloc_tag), 32'd1);
        cdb(4'd0, 32'h1234, 0, 32'd0);
`ifdef ROB_COMMIT_BYPASS_EN
        cmp("lit039_valid", 32'(ROB_data_valid), 32'd1);
        cmp("lit039_data", ROB_data, 32'h1234);
        idle();
        cmp("lit039_valid_drop", 32'(ROB_data_valid), 32'd0);
`else
        cmp("lit034_not_yet", 32'(ROB_data_valid), 32'd0);
        idle();
        cmp("lit034_valid", 32'(ROB_data_valid), 32'd1);
        cmp("lit034_dest", 32'(ROB_reg_dest), 32'd5);
        cmp("lit034_tag", 32'(ROB_tag), 32'd0);
        cmp("lit034_data", ROB_data, 32'h1234);
        idle();
        cmp("lit034_valid_drop", 32'(ROB_data_valid), 32'd0);
`endif

        // Fill, overflow attempt, wrap.
        doReset();
        for (int i = 0; i < DEPTH; i++) alloc(5'(i + 1));
        cmp("lit035_full", 32'(full), 32'd1);
        cmp("lit035_tag_wrap", 32'(alloc_tag), 32'd0);
        alloc(5'd17);
        cmp("lit035_full_hold", 32'(full), 32'd1);
        cdb(4'd0, 32'hAA, 0, 32'd0);
`ifdef ROB_COMMIT_BYPASS_EN
        cmp("lit035_commit", 32'(ROB_data_valid), 32'd1);
        idle();
`else
        idle();
        cmp("lit035_commit", 32'(ROB_data_valid), 32'd1);
`endif
        cmp("lit035_commit_dest", 32'(ROB_reg_dest), 32'd1);
        cmp("lit035_full_drop", 32'(full), 32'd0);
        cmp("lit035_next_tag", 32'(alloc_tag), 32'd0);
        alloc(5'd20);
        cmp("lit035_after_alloc", 32'(alloc_tag), 32'd1);

        // Out-of-order completion, in-order commit.
        doReset();
        alloc(5'd7); alloc(5'd8); alloc(5'd9);
        cdb(4'd2, 32'h22, 0, 32'd0);
        cdb(4'd1, 32'h11, 0, 32'd0);
        cdb(4'd0, 32'h00, 0, 32'd0);
        seen[0] = int'(ROB_data_valid); seenTag[0] = int'(ROB_tag);
        for (int i = 1; i < 4; i++) begin
            idle();
            seen[i] = int'(ROB_data_valid); seenTag[i] = int'(ROB_tag);
        end
        for (int i = 0; i < 3; i++) begin
`ifdef ROB_COMMIT_BYPASS_EN
            cmp("lit036_valid", 32'(seen[i]), 32'd1);
            cmp("lit036_order", 32'(seenTag[i]), 32'(i));
`else
            cmp("lit036_valid", 32'(seen[i + 1]), 32'd1);
            cmp("lit036_order", 32'(seenTag[i + 1]), 32'(i));
`endif
        end

        // Mispredict flush.
        doReset();
        alloc(5'd3); alloc(5'd4);
        cdb(4'd0, 32'h55, 1, 32'h80);
`ifndef ROB_COMMIT_BYPASS_EN
        idle();
`endif
        cmp("lit037_valid", 32'(ROB_data_valid), 32'd1);
        cmp("lit037_clear", 32'(clear), 32'd1);
        cmp("lit037_clear_pc", clear_pc, 32'h80);
        cmp("lit037_alloc_tag", 32'(alloc_tag), 32'd0);
        idle();
        cmp("lit037_clear_drop", 32'(clear), 32'd0);
        cdb(4'd1, 32'h66, 0, 32'd0);
        idle();
        cmp("lit037_no_commit", 32'(ROB_data_valid), 32'd0);

        // Stall with a ready head.
        doReset();
        alloc(5'd10); alloc(5'd11);
        cdb(4'd1, 32'h1, 0, 32'd0);
        cdb(4'd0, 32'h0, 0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 5'd0, 0, '0, 32'd0, 0, 32'd0);
            cmp("lit038_stalled", 32'(ROB_data_valid), 32'd0);
        end
        idle();
        cmp("lit038_resume", 32'(ROB_data_valid), 32'd1);
`ifdef ROB_COMMIT_BYPASS_EN
        cmp("lit038_tag", 32'(ROB_tag), 32'd1);
`else
        cmp("lit038_tag", 32'(ROB_tag), 32'd0);
`endif

        // Randomized traffic against the model.
        doReset();
        for (int n = 0; n < 3000; n++) begin
            bit          r  = ($urandom_range(0, 99) < 85);
            bit          av = ($urandom_range(0, 99) < 55);
            bit          cv = ($urandom_range(0, 99) < 60);
            bit          cm = ($urandom_range(0, 99) < 4);
            logic [TAG_W-1:0] ct;
            if (mq.size() > 0 && $urandom_range(0, 9) < 8)
                ct = TAG_W'((mHead + int'($urandom_range(0, mq.size() - 1))) % DEPTH);
            else
                ct = TAG_W'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 399) == 0)
                doReset();
            else
                applyStimulus(r, av, 5'($urandom_range(0, 31)), cv, ct,
                              $urandom, cm, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
